locker_code_fsm: RTL

//   Code-entry controller for the Locker design; directly upstream of RS_EN.

---
 rtl/locker_code_fsm_if.sv | 23 ++
 rtl/locker_code_fsm.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/locker_code_fsm_if.sv
// Keypad / lock-request bundle between the keypad front end (master) and the
// code-entry controller (slave), including the controller's status outputs.
interface locker_code_fsm_if;
  logic       key_valid;
  logic [3:0] key_val;
  logic       lock_req;
  logic       S;
  logic       R;
  logic       err;
  logic       lockout;
  logic [3:0] digit_cnt;
  logic [3:0] tries;

  modport master (
    output key_valid, key_val, lock_req,
    input  S, R, err, lockout, digit_cnt, tries
  );

  modport slave (
    input  key_valid, key_val, lock_req,
    output S, R, err, lockout, digit_cnt, tries
  );
endinterface

// File: rtl/locker_code_fsm.sv
// Code-entry controller for the Locker: collects keypad digits, compares them to
// a stored code and emits one-cycle S (unlock) / R (lock) pulses for RS_EN.
// Too many consecutive wrong codes put the controller into a timed lockout.
module locker_code_fsm #(
  parameter int                  DIGITS      = 4,
  parameter logic [DIGITS*4-1:0] CODE        = 16'h1234,
  parameter int                  MAX_TRIES   = 3,
  parameter int                  LOCKOUT_CYC = 100
) (
  input logic               C,
  input logic               RST,
  locker_code_fsm_if.slave  bus
);

  localparam int W  = DIGITS * 4;
  localparam int TW = $clog2(LOCKOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    CHECK,
    OPEN,
    FAIL,
    LOCKOUT
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  entry_q, entry_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    tries_q, tries_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          lock_prev_q;
  logic          s_q, s_d;
  logic          r_q, r_d;
  logic          err_q, err_d;
  logic          lockout_q, lockout_d;

  logic          lock_rise;
  logic          is_digit;
  logic          is_clear;
  logic          code_ok;
  logic [3:0]    cnt_inc;
  logic [3:0]    tries_inc;
  logic [W-1:0]  entry_shift;

  // A held lock_req must only produce a single R pulse, so everything keys off its rising edge.
  assign lock_rise   = bus.lock_req & ~lock_prev_q;
  assign is_digit    = bus.key_valid && (bus.key_val <= 4'd9);
  assign is_clear    = bus.key_valid && (bus.key_val == 4'hF);
  assign code_ok     = (entry_q == CODE);
  assign cnt_inc     = cnt_q + 4'd1;
  assign tries_inc   = (tries_q >= 4'(MAX_TRIES)) ? tries_q : (tries_q + 4'd1);
  assign entry_shift = (entry_q << 4) | W'(bus.key_val);

  // State register plus all registered outputs; reset discards any attempt or lockout.
  always_ff @(posedge C) begin
    if (RST) begin
      state_q     <= IDLE;
      entry_q     <= '0;
      cnt_q       <= '0;
      tries_q     <= '0;
      timer_q     <= '0;
      lock_prev_q <= 1'b0;
      s_q         <= 1'b0;
      r_q         <= 1'b0;
      err_q       <= 1'b0;
      lockout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      entry_q     <= entry_d;
      cnt_q       <= cnt_d;
      tries_q     <= tries_d;
      timer_q     <= timer_d;
      lock_prev_q <= bus.lock_req;
      s_q         <= s_d;
      r_q         <= r_d;
      err_q       <= err_d;
      lockout_q   <= lockout_d;
    end
  end

  // Next-state logic: digit collection, code check, failure counting and lockout timing.
  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    cnt_d   = cnt_q;
    tries_d = tries_q;
    timer_d = timer_q;
    unique case (state_q)
      IDLE: begin
        if (lock_rise) begin
          entry_d = '0;
          cnt_d   = '0;
        end else if (is_digit) begin
          entry_d = entry_shift;
          cnt_d   = 4'd1;
          state_d = (DIGITS == 1) ? CHECK : ENTRY;
        end
      end
      ENTRY: begin
        if (lock_rise || is_clear) begin
          entry_d = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (is_digit) begin
          entry_d = entry_shift;
          cnt_d   = cnt_inc;
          if (cnt_inc == 4'(DIGITS)) begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        entry_d = '0;
        cnt_d   = '0;
        if (code_ok) begin
          tries_d = '0;
          // A lock request arriving with a correct code wins: stay locked.
          state_d = lock_rise ? IDLE : OPEN;
        end else begin
          tries_d = tries_inc;
          if (tries_inc == 4'(MAX_TRIES)) begin
            state_d = LOCKOUT;
            timer_d = TW'(LOCKOUT_CYC);
          end else begin
            state_d = FAIL;
          end
        end
      end
      FAIL: begin
        state_d = IDLE;
      end
      OPEN: begin
        if (lock_rise) begin
          state_d = IDLE;
        end
      end
      LOCKOUT: begin
        timer_d = timer_q - TW'(1);
        if (timer_q <= TW'(1)) begin
          state_d = IDLE;
          tries_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic: computes next-cycle pulse/level values, registered alongside the state.
  always_comb begin
    s_d       = (state_q == CHECK) && code_ok && !lock_rise;
    r_d       = lock_rise;
    err_d     = (state_d == FAIL);
    lockout_d = (state_d == LOCKOUT);
  end

  assign bus.S         = s_q;
  assign bus.R         = r_q;
  assign bus.err       = err_q;
  assign bus.lockout   = lockout_q;
  assign bus.digit_cnt = cnt_q;
  assign bus.tries     = tries_q;

endmodule
